// File: rtl/issue_ctrl.sv
// In-order issue stage: one-entry output register, load scoreboard, RUN/BR_WAIT/EXCP serialiser.
// Accept-to-out_valid is 1 cycle; in_ready drops on hazard, full output register, non-RUN state or flush.
module issue_ctrl #(
    parameter int NREG  = 32,
    parameter int PC_W  = 64,
    parameter int SAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rs1_en,
    input  logic              in_rs2_en,
    input  logic              in_rd_en,
    input  logic              in_mem_read,
    input  logic              in_ctrl,
    input  logic              in_reversed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [4:0]        out_rd,
    output logic              out_rd_en,
    input  logic              wb_valid,
    input  logic [4:0]        wb_rd,
    input  logic              br_done,
    input  logic              flush,
    output logic              excp_valid,
    output logic [PC_W-1:0]   excp_pc,
    output logic [NREG-1:0]   busy_mask,
    output logic [SAT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {RUN, BR_WAIT, EXCP} state_t;

    localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic              out_rd_en_q, out_rd_en_d;
    logic              excp_valid_q, excp_valid_d;
    logic [PC_W-1:0]   excp_pc_q, excp_pc_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [SAT_W-1:0]  stall_q, stall_d;

    logic [NREG-1:0]   wb_clr, busy_set, busy_eff;
    logic              hazard, accept, issue, stall_inc;

    // A same-cycle writeback lets the dependent instruction through immediately.
    assign wb_clr   = (wb_valid && wb_rd != 5'd0) ? (ONE << wb_rd) : '0;
    assign busy_eff = busy_q & ~wb_clr;
    assign hazard   = (in_rs1_en && busy_eff[in_rs1]) ||
                      (in_rs2_en && busy_eff[in_rs2]) ||
                      (in_rd_en  && busy_eff[in_rd]);

    assign in_ready  = !rst && (state_q == RUN) && !flush &&
                       (!out_valid_q || out_ready) && (in_reversed || !hazard);
    assign accept    = in_valid && in_ready;
    assign issue     = accept && !in_reversed;
    assign stall_inc = (state_q == RUN) && in_valid && !in_reversed && hazard && !flush;
    assign busy_set  = (issue && in_mem_read && in_rd_en && in_rd != 5'd0) ? (ONE << in_rd) : '0;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_rd_d     = out_rd_q;
        out_rd_en_d  = out_rd_en_q;
        excp_valid_d = excp_valid_q;
        excp_pc_d    = excp_pc_q;
        // Set wins over a coincident clear; x0 is never tracked.
        busy_d       = busy_eff | busy_set;
        busy_d[0]    = 1'b0;
        stall_d      = (stall_inc && stall_q != '1) ? stall_q + SAT_W'(1) : stall_q;

        if (flush) begin
            state_d      = RUN;
            out_valid_d  = 1'b0;
            excp_valid_d = 1'b0;
        end else begin
            if (issue) begin
                out_valid_d = 1'b1;
                out_pc_d    = in_pc;
                out_rd_d    = in_rd;
                out_rd_en_d = in_rd_en;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                RUN: begin
                    if (accept && in_reversed) begin
                        state_d      = EXCP;
                        excp_valid_d = 1'b1;
                        excp_pc_d    = in_pc;
                    end else if (issue && in_ctrl) begin
                        state_d = BR_WAIT;
                    end
                end
                BR_WAIT: if (br_done) state_d = RUN;
                EXCP:    state_d = EXCP;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_rd_q     <= '0;
            out_rd_en_q  <= 1'b0;
            excp_valid_q <= 1'b0;
            excp_pc_q    <= '0;
            busy_q       <= '0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_rd_q     <= out_rd_d;
            out_rd_en_q  <= out_rd_en_d;
            excp_valid_q <= excp_valid_d;
            excp_pc_q    <= excp_pc_d;
            busy_q       <= busy_d;
            stall_q      <= stall_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_rd     = out_rd_q;
    assign out_rd_en  = out_rd_en_q;
    assign excp_valid = excp_valid_q;
    assign excp_pc    = excp_pc_q;
    assign busy_mask  = busy_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed table, hand-written corner sequences and randomized traffic vs a model.
// The stall counter is instantiated narrow so that saturation is reachable.
module tb_issue_ctrl;

    localparam int SW     = 4;
    localparam int SATMAX = (1 << SW) - 1;
    localparam int M_RUN  = 0;
    localparam int M_BR   = 1;
    localparam int M_EX   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [63:0]   in_pc;
    logic [4:0]    in_rs1, in_rs2, in_rd;
    logic          in_rs1_en, in_rs2_en, in_rd_en;
    logic          in_mem_read, in_ctrl, in_reversed;
    logic          out_valid, out_ready;
    logic [63:0]   out_pc;
    logic [4:0]    out_rd;
    logic          out_rd_en;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          br_done, flush;
    logic          excp_valid;
    logic [63:0]   excp_pc;
    logic [31:0]   busy_mask;
    logic [SW-1:0] stall_cnt;

    always #5 clk = ~clk;

    issue_ctrl #(.NREG(32), .PC_W(64), .SAT_W(SW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_en(in_rd_en),
        .in_mem_read(in_mem_read), .in_ctrl(in_ctrl), .in_reversed(in_reversed),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd(out_rd), .out_rd_en(out_rd_en),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .br_done(br_done), .flush(flush),
        .excp_valid(excp_valid), .excp_pc(excp_pc),
        .busy_mask(busy_mask), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_state;
    bit          m_busy [32];
    bit          m_ov, m_rden, m_ev;
    logic [63:0] m_pc, m_epc;
    logic [4:0]  m_rd;
    int          m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_RUN;
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_ov = 0; m_rden = 0; m_ev = 0; m_pc = '0; m_epc = '0; m_rd = '0; m_cnt = 0;
    endtask

    function automatic bit pending(input logic [4:0] r);
        return m_busy[r] && !(wb_valid && wb_rd == r);
    endfunction

    function automatic bit m_hazard();
        return (in_rs1_en && pending(in_rs1)) || (in_rs2_en && pending(in_rs2)) ||
               (in_rd_en && pending(in_rd));
    endfunction

    task automatic drive_idle();
        in_valid = 0; in_pc = '0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_en = 0; in_rs2_en = 0; in_rd_en = 0;
        in_mem_read = 0; in_ctrl = 0; in_reversed = 0;
        out_ready = 1; wb_valid = 0; wb_rd = 0; br_done = 0; flush = 0;
    endtask

    task automatic set_op(input logic [63:0] pc, input logic [4:0] rs1, input bit e1,
                          input logic [4:0] rd, input bit ed, input bit mr, input bit ctrl, input bit rev);
        in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs1_en = e1; in_rs2 = 0; in_rs2_en = 0;
        in_rd = rd; in_rd_en = ed; in_mem_read = mr; in_ctrl = ctrl; in_reversed = rev;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_pc"}, out_pc, 0);
        chk({tag, "_out_rd"}, {out_rd_en, out_rd}, 0);
        chk({tag, "_excp"}, {excp_valid, excp_pc[62:0]}, 0);
        chk({tag, "_busy"}, busy_mask, 0);
        chk({tag, "_stall"}, stall_cnt, 0);
    endtask

    // One clock: compare DUT with model, advance model across the edge, return at next negedge.
    task automatic step();
        bit hz, rdy, acc;
        logic [31:0] bm;
        #1;
        hz  = m_hazard();
        rdy = (m_state == M_RUN) && !flush && (!m_ov || out_ready) && (in_reversed || !hz);
        acc = in_valid && rdy;
        for (int i = 0; i < 32; i++) bm[i] = m_busy[i];
        chk("in_ready", in_ready, rdy);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_rd", {out_rd_en, out_rd}, {m_rden, m_rd});
        end
        chk("excp_valid", excp_valid, m_ev);
        if (m_ev) chk("excp_pc", excp_pc, m_epc);
        chk("busy_mask", busy_mask, bm);
        chk("stall_cnt", stall_cnt, m_cnt);
        @(posedge clk);
        if (m_state == M_RUN && in_valid && !in_reversed && hz && !flush && m_cnt < SATMAX)
            m_cnt++;
        if (wb_valid) m_busy[wb_rd] = 0;
        if (acc && !in_reversed && in_mem_read && in_rd_en && in_rd != 0) m_busy[in_rd] = 1;
        if (flush) begin
            m_ov = 0; m_ev = 0; m_state = M_RUN;
        end else begin
            if (acc && !in_reversed) begin
                m_ov = 1; m_pc = in_pc; m_rd = in_rd; m_rden = in_rd_en;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (acc && in_reversed) begin
                m_ev = 1; m_epc = in_pc; m_state = M_EX;
            end else if (acc && in_ctrl) begin
                m_state = M_BR;
            end else if (m_state == M_BR && br_done) begin
                m_state = M_RUN;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 0;
    endtask

    typedef struct {
        bit          v;
        logic [63:0] pc;
        logic [4:0]  rs1;
        bit          e1;
        logic [4:0]  rd;
        bit          ed, mr, wbv;
        logic [4:0]  wbrd;
        bit          exp_rdy;
        int          exp_cnt;
        logic [31:0] exp_busy;
    } vec_t;

    function automatic vec_t mk(input bit v, input logic [63:0] pc, input logic [4:0] rs1, input bit e1,
                                input logic [4:0] rd, input bit ed, input bit mr, input bit wbv,
                                input logic [4:0] wbrd, input bit rdy, input int cnt, input logic [31:0] busy);
        vec_t r;
        r.v = v; r.pc = pc; r.rs1 = rs1; r.e1 = e1; r.rd = rd; r.ed = ed; r.mr = mr;
        r.wbv = wbv; r.wbrd = wbrd; r.exp_rdy = rdy; r.exp_cnt = cnt; r.exp_busy = busy;
        return r;
    endfunction

    vec_t tbl [$];

    initial begin
        rst = 1;
        drive_idle();
        model_reset();
        #1;
        check_zero("async_reset0");
        do_reset();

        // back-to-back, load-use, WAW with coincident set/clear, x0 load
        tbl.push_back(mk(1, 64'h0,  1, 1, 3, 1, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 64'h4,  1, 1, 3, 1, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 64'h8,  1, 1, 3, 1, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 64'hC,  1, 1, 3, 1, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 64'h10, 1, 1, 5, 1, 1, 0, 0, 1, 0, 32'h0));
        tbl.push_back(mk(1, 64'h14, 5, 1, 6, 1, 0, 0, 0, 0, 0, 32'h20));
        tbl.push_back(mk(1, 64'h14, 5, 1, 6, 1, 0, 0, 0, 0, 1, 32'h20));
        tbl.push_back(mk(1, 64'h14, 5, 1, 6, 1, 0, 1, 5, 1, 2, 32'h20));
        tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h0));
        tbl.push_back(mk(1, 64'h20, 1, 1, 7, 1, 1, 0, 0, 1, 2, 32'h0));
        tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h80));
        tbl.push_back(mk(1, 64'h24, 1, 1, 7, 1, 1, 1, 7, 1, 2, 32'h80));
        tbl.push_back(mk(1, 64'h28, 1, 1, 7, 1, 1, 0, 0, 0, 2, 32'h80));
        tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 1, 7, 1, 3, 32'h80));
        tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0));
        tbl.push_back(mk(1, 64'h30, 0, 1, 0, 1, 1, 0, 0, 1, 3, 32'h0));
        tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h0));
        foreach (tbl[i]) begin
            drive_idle();
            in_valid = tbl[i].v; in_pc = tbl[i].pc; in_rs1 = tbl[i].rs1; in_rs1_en = tbl[i].e1;
            in_rd = tbl[i].rd; in_rd_en = tbl[i].ed; in_mem_read = tbl[i].mr;
            wb_valid = tbl[i].wbv; wb_rd = tbl[i].wbrd;
            #1;
            chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].exp_rdy);
            chk($sformatf("tbl%0d_cnt", i), stall_cnt, tbl[i].exp_cnt);
            chk($sformatf("tbl%0d_busy", i), busy_mask, tbl[i].exp_busy);
            step();
        end

        // branch serialisation, released by br_done
        drive_idle();
        set_op(64'h100, 1, 1, 0, 0, 0, 1, 0);
        step();
        set_op(64'h104, 1, 1, 3, 1, 0, 0, 0);
        repeat (2) begin #1 chk("br_wait_rdy", in_ready, 0); step(); end
        br_done = 1;
        #1 chk("br_done_rdy", in_ready, 0);
        step();
        br_done = 0;
        #1 chk("br_resume_rdy", in_ready, 1);
        step();
        chk("br_resume_pc", out_pc, 64'h104);
        chk("br_resume_ov", out_valid, 1);

        // branch serialisation, released by flush while execute is stalled
        set_op(64'h200, 1, 1, 0, 0, 0, 1, 0);
        step();
        set_op(64'h204, 1, 1, 3, 1, 0, 0, 0);
        out_ready = 0;
        step();
        chk("fl_pre_ov", out_valid, 1);
        flush = 1; br_done = 1;
        #1 chk("fl_rdy", in_ready, 0);
        step();
        flush = 0; br_done = 0; out_ready = 1;
        chk("fl_ov", out_valid, 0);
        #1 chk("fl_resume_rdy", in_ready, 1);
        step();
        chk("fl_resume_pc", out_pc, 64'h204);

        // illegal instruction with a load in flight
        drive_idle();
        set_op(64'h1F0, 0, 0, 9, 1, 1, 0, 0);
        step();
        set_op(64'h2000, 1, 1, 3, 1, 0, 0, 1);
        step();
        chk("ex_vld", excp_valid, 1);
        chk("ex_pc", excp_pc, 64'h2000);
        chk("ex_no_issue", out_valid, 0);
        set_op(64'h2004, 1, 1, 3, 1, 0, 0, 0);
        repeat (3) begin #1 chk("ex_rdy", in_ready, 0); step(); chk("ex_hold", excp_valid, 1); end
        flush = 1;
        step();
        flush = 0;
        chk("ex_flush_clr", excp_valid, 0);
        chk("ex_busy_keep", busy_mask[9], 1);
        drive_idle();
        wb_valid = 1; wb_rd = 9;
        step();

        // backpressure with a hazard, then asynchronous reset mid-stall
        drive_idle();
        out_ready = 0;
        set_op(64'h300, 0, 0, 10, 1, 1, 0, 0);
        step();
        set_op(64'h304, 10, 1, 11, 1, 0, 0, 0);
        repeat (3) begin
            #1 chk("bp_rdy", in_ready, 0);
            step();
            chk("bp_pc", out_pc, 64'h300);
            chk("bp_ov", out_valid, 1);
        end
        chk("bp_cnt", stall_cnt, 6);
        chk("bp_busy", busy_mask, 32'h400);
        #2 rst = 1;
        #1 check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst = 0;
        drive_idle();

        // stall counter saturation
        set_op(64'h400, 0, 0, 11, 1, 1, 0, 0);
        step();
        set_op(64'h404, 11, 1, 12, 1, 0, 0, 0);
        repeat (20) step();
        chk("sat_cnt", stall_cnt, SATMAX);
        drive_idle();
        wb_valid = 1; wb_rd = 11;
        step();

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            in_valid    = ($urandom_range(3) != 0);
            in_pc       = {$urandom, $urandom};
            in_rs1      = 5'($urandom_range(7));
            in_rs2      = 5'($urandom_range(7));
            in_rd       = 5'($urandom_range(7));
            in_rs1_en   = $urandom_range(1);
            in_rs2_en   = $urandom_range(1);
            in_rd_en    = ($urandom_range(3) != 0);
            in_mem_read = ($urandom_range(2) == 0);
            in_ctrl     = ($urandom_range(7) == 0);
            in_reversed = ($urandom_range(15) == 0);
            out_ready   = ($urandom_range(3) != 0);
            wb_valid    = ($urandom_range(2) == 0);
            wb_rd       = 5'($urandom_range(7));
            br_done     = ($urandom_range(3) == 0);
            flush       = ($urandom_range(19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
